// File: rtl/datapath_md_pkg.sv
// datapath_md_pkg
//   Shared encodings for the multicycle datapath and its iterative
//   multiply/divide unit. It holds the ALU operation codes, the mul/div
//   operation codes, the next-PC and write-back select encodings, the PSR
//   bit positions and the mul/div FSM state type.
package datapath_md_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_MOV  = 4'd5,
        ALU_LSH  = 4'd6,
        ALU_ASHR = 4'd7,
        ALU_CMP  = 4'd8,
        ALU_LUI  = 4'd9
    } aluOpE;

    typedef enum logic [1:0] {
        MD_MULU = 2'd0,
        MD_MULS = 2'd1,
        MD_DIVU = 2'd2,
        MD_REMU = 2'd3
    } mdOpE;

    typedef enum logic [1:0] {
        PC_INC  = 2'd0,
        PC_REL  = 2'd1,
        PC_REG  = 2'd2,
        PC_HOLD = 2'd3
    } pcSelE;

    typedef enum logic [1:0] {
        WB_RESULT = 2'd0,
        WB_MEM    = 2'd1,
        WB_LO     = 2'd2,
        WB_HI     = 2'd3
    } wbSelE;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } mdStateE;

    localparam int PSR_C = 0;
    localparam int PSR_L = 1;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 6;
    localparam int PSR_N = 7;

endpackage

// File: rtl/datapath_md_muldiv.sv
// muldiv_iter
//   Iterative multiply/divide unit: one shift-add (multiply) or one
//   restoring-subtract (divide/remainder) step per clock, WIDTH steps per
//   operation. Operands are captured when start is accepted in IDLE, so the
//   register file may change while the unit runs.
// Ports
//   clk, reset   clock, asynchronous active-high reset
//   start        request; honoured only in IDLE
//   op           MULU / MULS / DIVU / REMU
//   opA, opB     operands sampled on the accepting edge
//   busy         high throughout RUN
//   done         one-cycle completion pulse (DONE state)
//   div0         sticky divide-by-zero flag, cleared by the next start
//   hi, lo       result registers
module muldiv_iter
    import datapath_md_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNTW = $clog2(WIDTH + 1);

    mdStateE          state;
    mdStateE          stateNext;
    logic [CNTW-1:0]  count;
    mdOpE             opReg;
    logic             negReg;

    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] accHi;
    logic [WIDTH-1:0] accLo;

    mdOpE             opSel;
    logic             startDiv;
    logic             divZero;
    logic             aNeg;
    logic             bNeg;
    logic [WIDTH-1:0] aMag;
    logic [WIDTH-1:0] bMag;
    logic             accept;
    logic             lastStep;

    logic             runDiv;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic             divFits;
    logic [WIDTH-1:0] stepHi;
    logic [WIDTH-1:0] stepLo;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prodNeg;
    logic [WIDTH-1:0] finalHi;
    logic [WIDTH-1:0] finalLo;

    // Operand preparation on the accepting edge. Signed multiply works on
    // magnitudes; the most negative value still fits as an unsigned magnitude.
    assign opSel    = mdOpE'(op);
    assign startDiv = (opSel == MD_DIVU) || (opSel == MD_REMU);
    assign divZero  = startDiv && (opB == '0);
    assign aNeg     = (opSel == MD_MULS) && opA[WIDTH-1];
    assign bNeg     = (opSel == MD_MULS) && opB[WIDTH-1];
    assign aMag     = aNeg ? ('0 - opA) : opA;
    assign bMag     = bNeg ? ('0 - opB) : opB;
    assign accept   = (state == MD_IDLE) && start;
    assign lastStep = (state == MD_RUN) && (count == CNTW'(1));

    // One iteration step. Multiply keeps the partial product in accHi and
    // shifts the multiplier out of accLo; divide shifts the dividend out of
    // accLo into the remainder in accHi and shifts quotient bits into accLo.
    always_comb begin
        runDiv   = (opReg == MD_DIVU) || (opReg == MD_REMU);
        mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, divisor} : '0);
        divShift = {accHi, accLo[WIDTH-1]};
        divFits  = divShift >= {1'b0, divisor};
        if (runDiv) begin
            stepHi = divFits ? (divShift[WIDTH-1:0] - divisor) : divShift[WIDTH-1:0];
            stepLo = {accLo[WIDTH-2:0], divFits};
        end else begin
            stepHi = mulSum[WIDTH:1];
            stepLo = {mulSum[0], accLo[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod    = {stepHi, stepLo};
        prodNeg = '0 - prod;
        finalHi = stepHi;
        finalLo = stepLo;
        case (opReg)
            MD_MULU: {finalHi, finalLo} = prod;
            MD_MULS: {finalHi, finalLo} = negReg ? prodNeg : prod;
            MD_DIVU: begin
                finalHi = stepHi;
                finalLo = stepLo;
            end
            MD_REMU: begin
                finalHi = stepLo;
                finalLo = stepHi;
            end
            default: {finalHi, finalLo} = prod;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= MD_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    stateNext = divZero ? MD_DONE : MD_RUN;
                end
            end
            MD_RUN: begin
                busy = 1'b1;
                if (count == CNTW'(1)) begin
                    stateNext = MD_DONE;
                end
            end
            MD_DONE: begin
                done      = 1'b1;
                stateNext = MD_IDLE;
            end
            default: stateNext = MD_IDLE;
        endcase
    end

    // Control and architecturally visible results. Reset mid-RUN clears
    // HI/LO and returns to IDLE, so no completion pulse follows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            opReg  <= MD_MULU;
            negReg <= 1'b0;
            div0   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else if (accept) begin
            count  <= CNTW'(WIDTH);
            opReg  <= opSel;
            negReg <= aNeg ^ bNeg;
            div0   <= divZero;
            if (divZero) begin
                hi <= opA;
                lo <= '1;
            end
        end else if (state == MD_RUN) begin
            count <= count - CNTW'(1);
            if (lastStep) begin
                hi <= finalHi;
                lo <= finalLo;
            end
        end
    end

    // Working registers; their contents are meaningless outside RUN.
    always_ff @(posedge clk) begin
        if (accept) begin
            divisor <= bMag;
            accHi   <= '0;
            accLo   <= aMag;
        end else if (state == MD_RUN) begin
            accHi <= stepHi;
            accLo <= stepLo;
        end
    end

endmodule

// File: rtl/datapath_md.sv
// datapath_md
//   Parametrised multicycle CPU datapath: PC, instruction register,
//   register file, ALU, result register, PSR and an iterative mul/div unit.
//   All enables and selects come from the external control FSM.
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   memdata               memory read data (instruction fetch / load / reg write)
//   pc_en, pc_sel         PC load and next-PC source (inc, pc+sext imm8, regB, hold)
//   instr_en              load instruction register from memdata
//   reg_write, link_dest  register write, to LINK_REG instead of instr[11:8]
//   wb_sel                write-back source (result, memdata, md lo, md hi)
//   src_b_imm, zero_ext   ALU B operand select and imm8 extension
//   alu_op                ALU operation
//   res_en, res_link      result register load, capture pc+1 instead of ALU
//   psr_en                PSR load from ALU flags
//   addr_sel              address = pc (1) or regB (0)
//   md_start, md_op       mul/div start and operation
//   address, mem_wdata    memory address and store data (regA)
//   instr, psr            instruction register, {N,Z,0,0,0,F,L,C}
//   md_busy, md_done, md_div0  mul/div status
module datapath_md
    import datapath_md_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int REGBITS  = 4,
    parameter int PC_RESET = 0,
    parameter int LINK_REG = (1 << REGBITS) - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] memdata,
    input  logic             pc_en,
    input  logic [1:0]       pc_sel,
    input  logic             instr_en,
    input  logic             reg_write,
    input  logic             link_dest,
    input  logic [1:0]       wb_sel,
    input  logic             src_b_imm,
    input  logic             zero_ext,
    input  logic [3:0]       alu_op,
    input  logic             res_en,
    input  logic             res_link,
    input  logic             psr_en,
    input  logic             addr_sel,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    output logic [WIDTH-1:0] address,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [15:0]      instr,
    output logic [7:0]       psr,
    output logic             md_busy,
    output logic             md_done,
    output logic             md_div0
);

    localparam int NREGS = 1 << REGBITS;
    localparam int SHW   = $clog2(WIDTH);

    logic [WIDTH-1:0]        pc;
    logic [WIDTH-1:0]        result;
    logic [WIDTH-1:0]        rf [NREGS];

    logic [REGBITS-1:0]      addrA;
    logic [REGBITS-1:0]      addrB;
    logic [REGBITS-1:0]      addrW;
    logic [WIDTH-1:0]        regA;
    logic [WIDTH-1:0]        regB;
    logic [WIDTH-1:0]        immSext;
    logic [WIDTH-1:0]        immExt;
    logic [WIDTH-1:0]        pcPlus1;
    logic [WIDTH-1:0]        pcNext;
    logic [WIDTH-1:0]        wbData;
    logic [WIDTH-1:0]        mdHi;
    logic [WIDTH-1:0]        mdLo;

    aluOpE                   aluOp;
    logic signed [WIDTH-1:0] aluA;
    logic signed [WIDTH-1:0] aluB;
    logic [SHW-1:0]          shamt;
    logic [WIDTH:0]          sum;
    logic [WIDTH:0]          diff;
    logic                    ltU;
    logic                    ltS;
    logic                    ovfAdd;
    logic                    ovfSub;
    logic [WIDTH-1:0]        aluResult;
    logic                    aluValid;
    logic                    isSubLike;
    logic                    cFlag;
    logic                    fFlag;
    logic [7:0]              aluFlags;

    // Register fields are the low REGBITS of the 4-bit instruction fields.
    assign addrA   = instr[8 +: REGBITS];
    assign addrB   = instr[0 +: REGBITS];
    assign addrW   = link_dest ? REGBITS'(LINK_REG) : addrA;
    assign regA    = rf[addrA];
    assign regB    = rf[addrB];

    assign immSext = {{(WIDTH-8){instr[7]}}, instr[7:0]};
    assign immExt  = zero_ext ? {{(WIDTH-8){1'b0}}, instr[7:0]} : immSext;
    assign pcPlus1 = pc + WIDTH'(1);

    assign address   = addr_sel ? pc : regB;
    assign mem_wdata = regA;

    always_comb begin
        pcNext = pc;
        case (pcSelE'(pc_sel))
            PC_INC:  pcNext = pcPlus1;
            PC_REL:  pcNext = pc + immSext;
            PC_REG:  pcNext = regB;
            PC_HOLD: pcNext = pc;
            default: pcNext = pc;
        endcase
    end

    always_comb begin
        wbData = result;
        case (wbSelE'(wb_sel))
            WB_RESULT: wbData = result;
            WB_MEM:    wbData = memdata;
            WB_LO:     wbData = mdLo;
            WB_HI:     wbData = mdHi;
            default:   wbData = result;
        endcase
    end

    // ALU operand and flag helpers
    assign aluOp  = aluOpE'(alu_op);
    assign aluA   = regA;
    assign aluB   = src_b_imm ? immExt : regB;
    assign shamt  = aluB[SHW-1:0];
    assign sum    = {1'b0, $unsigned(aluA)} + {1'b0, $unsigned(aluB)};
    assign diff   = {1'b0, $unsigned(aluA)} - {1'b0, $unsigned(aluB)};
    assign ltU    = $unsigned(aluA) < $unsigned(aluB);
    assign ltS    = aluA < aluB;
    assign ovfAdd = (aluA[WIDTH-1] == aluB[WIDTH-1]) && (sum[WIDTH-1] != aluA[WIDTH-1]);
    assign ovfSub = (aluA[WIDTH-1] != aluB[WIDTH-1]) && (diff[WIDTH-1] != aluA[WIDTH-1]);

    always_comb begin
        aluResult = '0;
        aluValid  = 1'b1;
        isSubLike = 1'b0;
        cFlag     = 1'b0;
        fFlag     = 1'b0;
        case (aluOp)
            ALU_ADD: begin
                aluResult = sum[WIDTH-1:0];
                cFlag     = sum[WIDTH];
                fFlag     = ovfAdd;
            end
            ALU_SUB, ALU_CMP: begin
                aluResult = diff[WIDTH-1:0];
                isSubLike = 1'b1;
                cFlag     = diff[WIDTH];
                fFlag     = ovfSub;
            end
            ALU_AND:  aluResult = aluA & aluB;
            ALU_OR:   aluResult = aluA | aluB;
            ALU_XOR:  aluResult = aluA ^ aluB;
            ALU_MOV:  aluResult = aluB;
            // A negative B shifts right (logical) by the low bits of B.
            ALU_LSH:  aluResult = aluB[WIDTH-1] ? ($unsigned(aluA) >> shamt)
                                                : ($unsigned(aluA) << shamt);
            ALU_ASHR: aluResult = aluA >>> shamt;
            ALU_LUI:  aluResult = $unsigned(aluB) << (WIDTH / 2);
            default:  aluValid  = 1'b0;
        endcase
    end

    // N is signed less-than for subtract/compare and the result sign for
    // every other operation; Z compares the operands directly on CMP.
    always_comb begin
        aluFlags = '0;
        if (aluValid) begin
            aluFlags[PSR_C] = cFlag;
            aluFlags[PSR_L] = ltU;
            aluFlags[PSR_F] = fFlag;
            aluFlags[PSR_Z] = (aluOp == ALU_CMP) ? (aluA == aluB) : (aluResult == '0);
            aluFlags[PSR_N] = isSubLike ? ltS : aluResult[WIDTH-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc     <= WIDTH'(PC_RESET);
            instr  <= '0;
            result <= '0;
            psr    <= '0;
        end else begin
            if (pc_en) begin
                pc <= pcNext;
            end
            if (instr_en) begin
                instr <= memdata[15:0];
            end
            // A compare only updates flags, never the result register.
            if (res_en && (res_link || (aluOp != ALU_CMP))) begin
                result <= res_link ? pcPlus1 : aluResult;
            end
            if (psr_en) begin
                psr <= aluFlags;
            end
        end
    end

    // Register file: combinational read, so a same-cycle read of the
    // register being written still sees the old contents.
    always_ff @(posedge clk) begin
        if (reg_write) begin
            rf[addrW] <= wbData;
        end
    end

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) uMulDiv (
        .clk   (clk),
        .reset (reset),
        .start (md_start),
        .op    (md_op),
        .opA   (regA),
        .opB   (regB),
        .busy  (md_busy),
        .done  (md_done),
        .div0  (md_div0),
        .hi    (mdHi),
        .lo    (mdLo)
    );

endmodule

// File: tb/tb_datapath_md.sv
// tb_datapath_md
//   Directed bench for datapath_md (WIDTH=16, REGBITS=4): reset values,
//   ALU results and flags, write bypass, PC sources and link write, and the
//   mul/div unit including timing, ignored restarts, divide-by-zero and
//   reset abort.
module tb_datapath_md;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] memdata;
    logic        pc_en;
    logic [1:0]  pc_sel;
    logic        instr_en;
    logic        reg_write;
    logic        link_dest;
    logic [1:0]  wb_sel;
    logic        src_b_imm;
    logic        zero_ext;
    logic [3:0]  alu_op;
    logic        res_en;
    logic        res_link;
    logic        psr_en;
    logic        addr_sel;
    logic        md_start;
    logic [1:0]  md_op;
    logic [15:0] address;
    logic [15:0] mem_wdata;
    logic [15:0] instr;
    logic [7:0]  psr;
    logic        md_busy;
    logic        md_done;
    logic        md_div0;

    int total = 0;
    int bad   = 0;
    int doneCount = 0;

    datapath_md #(
        .WIDTH    (16),
        .REGBITS  (4),
        .PC_RESET (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memdata   (memdata),
        .pc_en     (pc_en),
        .pc_sel    (pc_sel),
        .instr_en  (instr_en),
        .reg_write (reg_write),
        .link_dest (link_dest),
        .wb_sel    (wb_sel),
        .src_b_imm (src_b_imm),
        .zero_ext  (zero_ext),
        .alu_op    (alu_op),
        .res_en    (res_en),
        .res_link  (res_link),
        .psr_en    (psr_en),
        .addr_sel  (addr_sel),
        .md_start  (md_start),
        .md_op     (md_op),
        .address   (address),
        .mem_wdata (mem_wdata),
        .instr     (instr),
        .psr       (psr),
        .md_busy   (md_busy),
        .md_done   (md_done),
        .md_div0   (md_div0)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (md_done === 1'b1) doneCount++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadInstr(input logic [15:0] word);
        memdata  = word;
        instr_en = 1'b1;
        tick();
        instr_en = 1'b0;
    endtask

    task automatic writeReg(input logic [3:0] r, input logic [15:0] val);
        loadInstr({4'h0, r, 8'h00});
        memdata   = val;
        wb_sel    = 2'd1;
        reg_write = 1'b1;
        tick();
        reg_write = 1'b0;
        wb_sel    = 2'd0;
    endtask

    // Write-back source sel into register dest, then read it on mem_wdata.
    task automatic readBack(input logic [3:0] dest, input logic [1:0] sel, output logic [15:0] val);
        loadInstr({4'h0, dest, 8'h00});
        wb_sel    = sel;
        reg_write = 1'b1;
        tick();
        reg_write = 1'b0;
        wb_sel    = 2'd0;
        val       = mem_wdata;
    endtask

    task automatic aluTo(input logic [15:0] word, input logic [3:0] op, input logic useImm,
                         input logic zext, input logic updPsr, input logic [3:0] dest,
                         output logic [15:0] val);
        loadInstr(word);
        alu_op    = op;
        src_b_imm = useImm;
        zero_ext  = zext;
        res_en    = 1'b1;
        psr_en    = updPsr;
        tick();
        res_en    = 1'b0;
        psr_en    = 1'b0;
        src_b_imm = 1'b0;
        zero_ext  = 1'b0;
        readBack(dest, 2'd0, val);
    endtask

    task automatic waitDone(input string tag);
        int n;
        n = 0;
        while (md_done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check(tag, {31'b0, md_done}, 32'd1);
    endtask

    task automatic runMd(input string tag, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] expLo, input logic [15:0] expHi);
        logic [15:0] v;
        writeReg(4'd1, a);
        writeReg(4'd2, b);
        loadInstr(16'h0102);
        md_op    = op;
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        waitDone({tag, "_done"});
        readBack(4'd6, 2'd2, v);
        check({tag, "_lo"}, {16'b0, v}, {16'b0, expLo});
        readBack(4'd7, 2'd3, v);
        check({tag, "_hi"}, {16'b0, v}, {16'b0, expHi});
    endtask

    initial begin
        logic [15:0] v;
        int n;
        int busyCnt;
        int d0;

        reset = 1'b1;
        memdata = '0; pc_en = 0; pc_sel = 0; instr_en = 0; reg_write = 0;
        link_dest = 0; wb_sel = 0; src_b_imm = 0; zero_ext = 0; alu_op = 0;
        res_en = 0; res_link = 0; psr_en = 0; addr_sel = 1'b1; md_start = 0; md_op = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", {16'b0, address}, 32'h0000);
        check("rst_instr", {16'b0, instr}, 32'h0000);
        check("rst_psr", {24'b0, psr}, 32'h00);
        check("rst_md_status", {29'b0, md_busy, md_done, md_div0}, 32'd0);
        reset = 1'b0;
        tick();

        // ALU and flags
        writeReg(4'd1, 16'h7FFF);
        writeReg(4'd2, 16'h0001);
        aluTo(16'h0102, 4'd0, 1'b0, 1'b0, 1'b1, 4'd4, v);
        check("add_result", {16'b0, v}, 32'h8000);
        check("add_psr", {24'b0, psr}, 32'h84);

        loadInstr(16'h0101);
        alu_op = 4'd8;
        psr_en = 1'b1;
        tick();
        psr_en = 1'b0;
        check("cmp_eq_psr", {24'b0, psr}, 32'h40);

        aluTo(16'h0201, 4'd1, 1'b0, 1'b0, 1'b1, 4'd5, v);
        check("sub_result", {16'b0, v}, 32'h8002);
        check("sub_psr", {24'b0, psr}, 32'h83);

        aluTo(16'h0404, 4'd7, 1'b1, 1'b1, 1'b0, 4'd6, v);
        check("ashr_result", {16'b0, v}, 32'hF800);
        aluTo(16'h0204, 4'd6, 1'b1, 1'b1, 1'b0, 4'd7, v);
        check("lsh_left", {16'b0, v}, 32'h0010);
        aluTo(16'h04FC, 4'd6, 1'b1, 1'b0, 1'b0, 4'd7, v);
        check("lsh_neg_right", {16'b0, v}, 32'h0008);
        aluTo(16'h0012, 4'd9, 1'b1, 1'b1, 1'b0, 4'd7, v);
        check("lui_result", {16'b0, v}, 32'h1200);

        // Same-cycle read of the register being written sees the old value.
        loadInstr(16'h0100);
        memdata   = 16'h5555;
        wb_sel    = 2'd1;
        reg_write = 1'b1;
        #1;
        check("bypass_old", {16'b0, mem_wdata}, 32'h7FFF);
        tick();
        reg_write = 1'b0;
        wb_sel    = 2'd0;
        check("bypass_new", {16'b0, mem_wdata}, 32'h5555);

        // Reset mid-fetch, also aborting a running multiply
        writeReg(4'd3, 16'h0042);
        loadInstr(16'h0003);
        pc_sel = 2'd2;
        pc_en  = 1'b1;
        tick();
        pc_en  = 1'b0;
        pc_sel = 2'd0;
        check("pc_from_regb", {16'b0, address}, 32'h0042);
        writeReg(4'd1, 16'h0005);
        writeReg(4'd2, 16'h0006);
        loadInstr(16'h0102);
        md_op    = 2'd0;
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        tick();
        check("abort_busy_before", {31'b0, md_busy}, 32'd1);
        memdata  = 16'hBEEF;
        instr_en = 1'b1;
        pc_en    = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("midrst_pc", {16'b0, address}, 32'h0000);
        check("midrst_psr", {24'b0, psr}, 32'h00);
        check("midrst_busy", {31'b0, md_busy}, 32'd0);
        check("midrst_instr", {16'b0, instr}, 32'h0000);
        instr_en = 1'b0;
        pc_en    = 1'b0;
        d0 = doneCount;
        tick();
        reset = 1'b0;
        repeat (24) tick();
        check("abort_no_done", doneCount - d0, 32'd0);
        readBack(4'd6, 2'd2, v);
        check("abort_lo", {16'b0, v}, 32'h0000);
        readBack(4'd7, 2'd3, v);
        check("abort_hi", {16'b0, v}, 32'h0000);

        // MULS timing and result
        writeReg(4'd1, 16'hFFFD);
        writeReg(4'd2, 16'h0007);
        loadInstr(16'h0102);
        md_op    = 2'd1;
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        busyCnt = 0;
        n = 0;
        while (md_done !== 1'b1 && n < 40) begin
            if (md_busy === 1'b1) busyCnt++;
            tick();
            n++;
        end
        check("muls_busy_cycles", busyCnt, 32'd16);
        check("muls_done_latency", n, 32'd16);
        tick();
        check("muls_done_pulse", {31'b0, md_done}, 32'd0);
        readBack(4'd6, 2'd2, v);
        check("muls_lo_wb", {16'b0, v}, 32'hFFEB);
        readBack(4'd7, 2'd3, v);
        check("muls_hi", {16'b0, v}, 32'hFFFF);

        // DIVU with ignored restart and operand overwrite during RUN
        writeReg(4'd1, 16'h0064);
        writeReg(4'd2, 16'h0007);
        loadInstr(16'h0102);
        md_op    = 2'd2;
        d0       = doneCount;
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        tick();
        tick();
        check("divu_busy", {31'b0, md_busy}, 32'd1);
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        writeReg(4'd1, 16'h0000);
        waitDone("divu_done");
        repeat (20) tick();
        check("divu_one_pulse", doneCount - d0, 32'd1);
        readBack(4'd6, 2'd2, v);
        check("divu_lo", {16'b0, v}, 32'h000E);
        readBack(4'd7, 2'd3, v);
        check("divu_hi", {16'b0, v}, 32'h0002);

        // Divide by zero
        writeReg(4'd1, 16'h1234);
        writeReg(4'd2, 16'h0000);
        loadInstr(16'h0102);
        md_op    = 2'd2;
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        check("div0_done", {31'b0, md_done}, 32'd1);
        check("div0_busy", {31'b0, md_busy}, 32'd0);
        check("div0_flag", {31'b0, md_div0}, 32'd1);
        tick();
        check("div0_pulse_end", {31'b0, md_done}, 32'd0);
        readBack(4'd6, 2'd2, v);
        check("div0_lo", {16'b0, v}, 32'hFFFF);
        readBack(4'd7, 2'd3, v);
        check("div0_hi", {16'b0, v}, 32'h1234);
        check("div0_sticky", {31'b0, md_div0}, 32'd1);
        writeReg(4'd2, 16'h0003);
        loadInstr(16'h0102);
        md_op    = 2'd0;
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        check("div0_cleared", {31'b0, md_div0}, 32'd0);
        waitDone("mulu_after_div0_done");
        readBack(4'd6, 2'd2, v);
        check("mulu_lo", {16'b0, v}, 32'h369C);
        readBack(4'd7, 2'd3, v);
        check("mulu_hi", {16'b0, v}, 32'h0000);

        runMd("mulu_max", 2'd0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE);
        runMd("muls_m1m1", 2'd1, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000);
        runMd("remu", 2'd3, 16'h0064, 16'h0007, 16'h0002, 16'h000E);

        // Link write and PC sources
        writeReg(4'd3, 16'h0010);
        loadInstr(16'h0003);
        pc_sel = 2'd2;
        pc_en  = 1'b1;
        tick();
        pc_en  = 1'b0;
        check("pc_0010", {16'b0, address}, 32'h0010);
        res_link = 1'b1;
        res_en   = 1'b1;
        tick();
        res_en   = 1'b0;
        res_link = 1'b0;
        link_dest = 1'b1;
        wb_sel    = 2'd0;
        reg_write = 1'b1;
        tick();
        reg_write = 1'b0;
        link_dest = 1'b0;
        loadInstr(16'h0F00);
        check("link_reg", {16'b0, mem_wdata}, 32'h0011);
        loadInstr(16'h00FE);
        pc_sel = 2'd1;
        pc_en  = 1'b1;
        tick();
        pc_en  = 1'b0;
        check("pc_rel_neg", {16'b0, address}, 32'h000E);
        memdata  = 16'hABCD;
        instr_en = 1'b1;
        pc_en    = 1'b1;
        pc_sel   = 2'd0;
        tick();
        instr_en = 1'b0;
        pc_en    = 1'b0;
        check("both_pc_inc", {16'b0, address}, 32'h000F);
        check("both_instr", {16'b0, instr}, 32'hABCD);
        pc_sel = 2'd3;
        pc_en  = 1'b1;
        tick();
        pc_en  = 1'b0;
        check("pc_hold", {16'b0, address}, 32'h000F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
